// File: rtl/tlb_tagged_pkg.sv
// Shared types and default sizing for the thread-tagged TLB.
package tlb_tagged_pkg;

    localparam int unsigned n_tlb_entries = 4;

    localparam int unsigned VpnW = 20;
    localparam int unsigned PpnW = 8;
    localparam int unsigned TidW = 3;
    localparam int unsigned CntW = 16;

    typedef logic [VpnW-1:0] vpn_t;
    typedef logic [PpnW-1:0] ppn_t;
    typedef logic [TidW-1:0] threadid_t;

    // Entry layout at the default sizing; the parametrised block mirrors this shape.
    typedef struct packed {
        logic      valid;
        threadid_t tid;
        vpn_t      vpn;
        ppn_t      ppn;
    } tlb_entry_t;

endpackage

// File: rtl/tlb_victim_sel.sv
// Picks the entry a write lands in: matching entry, else lowest free, else round-robin victim.
module tlb_victim_sel
    import tlb_tagged_pkg::*;
#(
    parameter int unsigned N_ENTRIES = n_tlb_entries,
    localparam int unsigned IdxW = $clog2(N_ENTRIES)
) (
    input  logic [N_ENTRIES-1:0] valid_i,
    input  logic [N_ENTRIES-1:0] match_i,
    input  logic [IdxW-1:0]      ptr_i,
    output logic [IdxW-1:0]      idx_o,
    output logic                 advance_o
);

    // Later loops override earlier ones, so a match beats a free slot beats the pointer.
    always_comb begin
        idx_o     = ptr_i;
        advance_o = 1'b1;
        for (int i = N_ENTRIES - 1; i >= 0; i--) begin
            if (!valid_i[i]) begin
                idx_o     = IdxW'(i);
                advance_o = 1'b0;
            end
        end
        for (int i = N_ENTRIES - 1; i >= 0; i--) begin
            if (match_i[i]) begin
                idx_o     = IdxW'(i);
                advance_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/tlb_tagged.sv
// Fully associative, thread-tagged TLB with 1-cycle lookup, selective flush,
// round-robin replacement and a saturating miss counter.
module tlb_tagged
    import tlb_tagged_pkg::*;
#(
    parameter int unsigned N_ENTRIES = n_tlb_entries,
    parameter int unsigned VPN_W     = VpnW,
    parameter int unsigned PPN_W     = PpnW,
    parameter int unsigned TID_W     = TidW,
    parameter int unsigned CNT_W     = CntW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             lookup_valid,
    input  logic [VPN_W-1:0] lookup_vpn,
    input  logic [TID_W-1:0] lookup_tid,
    input  logic             supervisor,
    output logic             resp_valid,
    output logic             resp_hit,
    output logic             resp_miss,
    output logic [PPN_W-1:0] resp_ppn,
    input  logic             write_en,
    input  logic [VPN_W-1:0] write_vpn,
    input  logic [PPN_W-1:0] write_ppn,
    input  logic [TID_W-1:0] write_tid,
    input  logic             flush_en,
    input  logic             flush_all,
    input  logic [TID_W-1:0] flush_tid,
    output logic [CNT_W-1:0] miss_count
);

    localparam int unsigned IdxW = $clog2(N_ENTRIES);

    typedef struct packed {
        logic             valid;
        logic [TID_W-1:0] tid;
        logic [VPN_W-1:0] vpn;
        logic [PPN_W-1:0] ppn;
    } entry_t;

    entry_t entry_q [N_ENTRIES];
    entry_t entry_d [N_ENTRIES];

    logic [IdxW-1:0]      ptr_q, ptr_d;
    logic [N_ENTRIES-1:0] valid_vec, lk_match, wr_match;
    logic                 lk_hit;
    logic [PPN_W-1:0]     lk_ppn;
    logic [IdxW-1:0]      wr_idx;
    logic                 wr_advance;

    logic             resp_valid_q, resp_valid_d;
    logic             resp_hit_q, resp_hit_d;
    logic             resp_miss_q, resp_miss_d;
    logic [PPN_W-1:0] resp_ppn_q, resp_ppn_d;
    logic [CNT_W-1:0] miss_count_q, miss_count_d;

    // CAM compare against current contents for both the lookup and the write ports.
    always_comb begin
        lk_ppn = '0;
        for (int i = 0; i < N_ENTRIES; i++) begin
            valid_vec[i] = entry_q[i].valid;
            lk_match[i]  = entry_q[i].valid && (entry_q[i].vpn == lookup_vpn)
                           && (entry_q[i].tid == lookup_tid);
            wr_match[i]  = entry_q[i].valid && (entry_q[i].vpn == write_vpn)
                           && (entry_q[i].tid == write_tid);
            // At most one entry matches, so OR-ing the selected ppns is a mux.
            if (lk_match[i]) begin
                lk_ppn = lk_ppn | entry_q[i].ppn;
            end
        end
        lk_hit = |lk_match;
    end

    tlb_victim_sel #(
        .N_ENTRIES (N_ENTRIES)
    ) u_victim_sel (
        .valid_i   (valid_vec),
        .match_i   (wr_match),
        .ptr_i     (ptr_q),
        .idx_o     (wr_idx),
        .advance_o (wr_advance)
    );

    // Response and miss-counter next state, from pre-update contents.
    always_comb begin
        resp_valid_d = lookup_valid;
        resp_hit_d   = 1'b0;
        resp_miss_d  = 1'b0;
        resp_ppn_d   = '0;
        miss_count_d = miss_count_q;
        if (lookup_valid) begin
            if (supervisor) begin
                resp_hit_d = 1'b1;
                resp_ppn_d = lookup_vpn[PPN_W-1:0];
            end else if (lk_hit) begin
                resp_hit_d = 1'b1;
                resp_ppn_d = lk_ppn;
            end else begin
                resp_miss_d = 1'b1;
                if (miss_count_q != '1) begin
                    miss_count_d = miss_count_q + CNT_W'(1);
                end
            end
        end
    end

    // Entry array next state; flush wins and drops any concurrent write.
    always_comb begin
        ptr_d = ptr_q;
        for (int i = 0; i < N_ENTRIES; i++) begin
            entry_d[i] = entry_q[i];
        end
        if (flush_en) begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                if (flush_all || (entry_q[i].tid == flush_tid)) begin
                    entry_d[i].valid = 1'b0;
                end
            end
        end else if (write_en) begin
            entry_d[wr_idx] = '{valid: 1'b1, tid: write_tid, vpn: write_vpn, ppn: write_ppn};
            if (wr_advance) begin
                ptr_d = ptr_q + IdxW'(1);
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                entry_q[i] <= '0;
            end
            ptr_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_hit_q   <= 1'b0;
            resp_miss_q  <= 1'b0;
            resp_ppn_q   <= '0;
            miss_count_q <= '0;
        end else begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                entry_q[i] <= entry_d[i];
            end
            ptr_q        <= ptr_d;
            resp_valid_q <= resp_valid_d;
            resp_hit_q   <= resp_hit_d;
            resp_miss_q  <= resp_miss_d;
            resp_ppn_q   <= resp_ppn_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_hit   = resp_hit_q;
    assign resp_miss  = resp_miss_q;
    assign resp_ppn   = resp_ppn_q;
    assign miss_count = miss_count_q;

endmodule

// File: tb/tb_tlb_tagged.sv
// Bench for tlb_tagged: scripted scenarios with literal checks, then random traffic
// checked every cycle against a behavioural model.
module tb_tlb_tagged;

    localparam int N  = 4;
    localparam int VW = 20;
    localparam int PW = 8;
    localparam int TW = 3;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          lookup_valid = 1'b0;
    logic [VW-1:0] lookup_vpn = '0;
    logic [TW-1:0] lookup_tid = '0;
    logic          supervisor = 1'b0;
    logic          write_en = 1'b0;
    logic [VW-1:0] write_vpn = '0;
    logic [PW-1:0] write_ppn = '0;
    logic [TW-1:0] write_tid = '0;
    logic          flush_en = 1'b0;
    logic          flush_all = 1'b0;
    logic [TW-1:0] flush_tid = '0;

    logic          resp_valid, resp_hit, resp_miss;
    logic [PW-1:0] resp_ppn;
    logic [CW-1:0] miss_count;
    logic          r2_valid, r2_hit, r2_miss;
    logic [PW-1:0] r2_ppn;
    logic [1:0]    miss_count2;

    always #5 clk = ~clk;

    tlb_tagged #(
        .N_ENTRIES (N), .VPN_W (VW), .PPN_W (PW), .TID_W (TW), .CNT_W (CW)
    ) dut (
        .clk (clk), .rst_n (rst_n),
        .lookup_valid (lookup_valid), .lookup_vpn (lookup_vpn), .lookup_tid (lookup_tid),
        .supervisor (supervisor),
        .resp_valid (resp_valid), .resp_hit (resp_hit), .resp_miss (resp_miss),
        .resp_ppn (resp_ppn),
        .write_en (write_en), .write_vpn (write_vpn), .write_ppn (write_ppn),
        .write_tid (write_tid),
        .flush_en (flush_en), .flush_all (flush_all), .flush_tid (flush_tid),
        .miss_count (miss_count)
    );

    // Narrow counter instance to exercise saturation.
    tlb_tagged #(
        .N_ENTRIES (N), .VPN_W (VW), .PPN_W (PW), .TID_W (TW), .CNT_W (2)
    ) dut2 (
        .clk (clk), .rst_n (rst_n),
        .lookup_valid (lookup_valid), .lookup_vpn (lookup_vpn), .lookup_tid (lookup_tid),
        .supervisor (supervisor),
        .resp_valid (r2_valid), .resp_hit (r2_hit), .resp_miss (r2_miss),
        .resp_ppn (r2_ppn),
        .write_en (write_en), .write_vpn (write_vpn), .write_ppn (write_ppn),
        .write_tid (write_tid),
        .flush_en (flush_en), .flush_all (flush_all), .flush_tid (flush_tid),
        .miss_count (miss_count2)
    );

    // Behavioural model state.
    bit            m_valid [N];
    logic [VW-1:0] m_vpn [N];
    logic [PW-1:0] m_ppn [N];
    logic [TW-1:0] m_tid [N];
    int            m_ptr;
    int            m_cnt, m_cnt2;
    logic          exp_valid, exp_hit, exp_miss;
    logic [PW-1:0] exp_ppn;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
        m_ptr = 0; m_cnt = 0; m_cnt2 = 0;
        exp_valid = 0; exp_hit = 0; exp_miss = 0; exp_ppn = '0;
    endtask

    // One clock edge of the model, applied to the inputs present at that edge.
    task automatic model_step();
        int found;
        int slot;
        exp_valid = lookup_valid; exp_hit = 0; exp_miss = 0; exp_ppn = '0;
        if (lookup_valid) begin
            if (supervisor) begin
                exp_hit = 1;
                exp_ppn = lookup_vpn[PW-1:0];
            end else begin
                found = -1;
                for (int i = 0; i < N; i++)
                    if (m_valid[i] && m_vpn[i] == lookup_vpn && m_tid[i] == lookup_tid) found = i;
                if (found >= 0) begin
                    exp_hit = 1;
                    exp_ppn = m_ppn[found];
                end else begin
                    exp_miss = 1;
                    if (m_cnt < 65535) m_cnt++;
                    if (m_cnt2 < 3) m_cnt2++;
                end
            end
        end
        if (flush_en) begin
            for (int i = 0; i < N; i++)
                if (flush_all || m_tid[i] == flush_tid) m_valid[i] = 1'b0;
        end else if (write_en) begin
            slot = -1;
            for (int i = 0; i < N; i++)
                if (m_valid[i] && m_vpn[i] == write_vpn && m_tid[i] == write_tid) slot = i;
            if (slot < 0) begin
                for (int i = N - 1; i >= 0; i--)
                    if (!m_valid[i]) slot = i;
            end
            if (slot < 0) begin
                slot  = m_ptr;
                m_ptr = (m_ptr + 1) % N;
            end
            m_valid[slot] = 1'b1;
            m_vpn[slot]   = write_vpn;
            m_ppn[slot]   = write_ppn;
            m_tid[slot]   = write_tid;
        end
    endtask

    // Compare process: model each active edge, then check both instances just after it.
    initial begin
        forever begin
            @(posedge clk);
            if (rst_n) begin
                model_step();
                #1;
                if (rst_n) begin
                    chk("valid", resp_valid, exp_valid);
                    chk("hit", resp_hit, exp_hit);
                    chk("miss", resp_miss, exp_miss);
                    chk("ppn", resp_ppn, exp_ppn);
                    chk("count", miss_count, m_cnt);
                    chk("valid2", r2_valid, exp_valid);
                    chk("hit2", r2_hit, exp_hit);
                    chk("ppn2", r2_ppn, exp_ppn);
                    chk("count2", miss_count2, m_cnt2);
                end
            end
        end
    end

    task automatic idle();
        lookup_valid = 0; lookup_vpn = '0; lookup_tid = '0; supervisor = 0;
        write_en = 0; write_vpn = '0; write_ppn = '0; write_tid = '0;
        flush_en = 0; flush_all = 0; flush_tid = '0;
    endtask

    // Drive one cycle of inputs; on return the response for them is on the outputs.
    task automatic do_cycle(input bit lv, input int lvpn, input int ltid, input bit sup,
                            input bit we, input int wvpn, input int wppn, input int wtid,
                            input bit fe, input bit fa, input int ft);
        lookup_valid = lv; lookup_vpn = VW'(lvpn); lookup_tid = TW'(ltid); supervisor = sup;
        write_en = we; write_vpn = VW'(wvpn); write_ppn = PW'(wppn); write_tid = TW'(wtid);
        flush_en = fe; flush_all = fa; flush_tid = TW'(ft);
        @(negedge clk);
        idle();
    endtask

    task automatic do_lookup(input int vpn, input int tid);
        do_cycle(1, vpn, tid, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_write(input int vpn, input int ppn, input int tid);
        do_cycle(0, 0, 0, 0, 1, vpn, ppn, tid, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst_n = 0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic expect_resp(input string name, input bit hit, input int ppn);
        chk({name, "_hit"}, resp_hit, hit);
        chk({name, "_miss"}, resp_miss, !hit);
        chk({name, "_ppn"}, resp_ppn, ppn);
    endtask

    initial begin
        idle();
        model_reset();
        #2;
        chk("rst_valid", resp_valid, 0);
        chk("rst_hit", resp_hit, 0);
        chk("rst_ppn", resp_ppn, 0);
        chk("rst_count", miss_count, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;

        // First miss, then install and hit, other thread misses.
        do_lookup('h12, 1);
        expect_resp("first", 0, 0);
        chk("first_count", miss_count, 1);
        do_write('h12, 'h3A, 1);
        do_lookup('h12, 1);
        expect_resp("installed", 1, 'h3A);
        do_lookup('h12, 2);
        expect_resp("other_tid", 0, 0);

        // Reset while a response is on the outputs drops it and empties the TLB.
        do_lookup('h12, 1);
        chk("inflight_valid", resp_valid, 1);
        rst_n = 0;
        model_reset();
        #1;
        chk("drop_valid", resp_valid, 0);
        chk("drop_hit", resp_hit, 0);
        chk("drop_ppn", resp_ppn, 0);
        chk("drop_count", miss_count, 0);
        @(negedge clk);
        rst_n = 1;
        do_lookup('h12, 1);
        expect_resp("after_rst", 0, 0);

        // Fill, then round-robin replacement and in-place update.
        do_reset();
        for (int i = 1; i <= 4; i++) do_write(i, 'h10 + i, 0);
        do_write(5, 'h15, 0);
        do_lookup(1, 0);
        expect_resp("evict_idx0", 0, 0);
        do_lookup(5, 0);
        expect_resp("new5", 1, 'h15);
        do_write(6, 'h16, 0);
        do_lookup(2, 0);
        expect_resp("evict_idx1", 0, 0);
        do_write(3, 'h77, 0);
        do_lookup(3, 0);
        expect_resp("inplace", 1, 'h77);
        do_write(7, 'h17, 0);
        do_lookup(3, 0);
        expect_resp("evict_idx2", 0, 0);
        do_lookup(4, 0);
        expect_resp("keep4", 1, 'h14);

        // Same-cycle write and lookup sees old contents.
        do_cycle(1, 'h40, 0, 0, 1, 'h40, 'h44, 0, 0, 0, 0);
        expect_resp("wr_same_cyc", 0, 0);
        do_lookup('h40, 0);
        expect_resp("wr_next_cyc", 1, 'h44);

        // Selective flush; flush drops a concurrent write; lookup sees pre-flush.
        do_reset();
        do_write('h100, 'h21, 1);
        do_write('h100, 'h22, 2);
        do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        do_lookup('h100, 1);
        expect_resp("flushed_t1", 0, 0);
        do_lookup('h100, 2);
        expect_resp("kept_t2", 1, 'h22);
        do_cycle(0, 0, 0, 0, 1, 'h200, 'h33, 3, 1, 0, 5);
        do_lookup('h200, 3);
        expect_resp("wr_dropped", 0, 0);
        do_cycle(1, 'h100, 2, 0, 0, 0, 0, 0, 1, 1, 0);
        expect_resp("pre_flush", 1, 'h22);
        do_lookup('h100, 2);
        expect_resp("post_flush", 0, 0);

        // Supervisor bypass, then counter saturation on the narrow instance.
        do_reset();
        do_cycle(1, 'hABCDE, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        expect_resp("super", 1, 'hDE);
        chk("super_count", miss_count, 0);
        for (int i = 0; i < 5; i++) do_lookup(i + 1, 0);
        chk("sat_count2", miss_count2, 3);
        chk("wide_count", miss_count, 5);

        // Random traffic on a small key space to keep replacement busy.
        for (int n = 0; n < 3000; n++) begin
            do_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 3),
                     $urandom_range(0, 15) == 0,
                     $urandom_range(0, 2) == 0, $urandom_range(0, 7), $urandom_range(0, 255),
                     $urandom_range(0, 3),
                     $urandom_range(0, 24) == 0, $urandom_range(0, 1) == 1,
                     $urandom_range(0, 3));
        end
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
